// File: rtl/hazard_ctrl.sv
// Hazard controller: shadows EX/MEM destination info to drive forwarding selects, load-use stalls, branch flushes and multi-cycle freezes.
// Latency: stall/flush/hold outputs are combinational in the same cycle; forwarding selects and busy_cnt are registered for the instruction's EX cycle.
// Backpressure: holds PC and IF/ID for one cycle on a load-use hazard and for MUL_LAT-1 cycles while a multi-cycle op occupies EX.
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int REG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rw,
  input  logic             id_regwr,
  input  logic             id_memrd,
  input  logic             id_mul,
  input  logic             ex_br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             ex_hold,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [3:0]       busy_cnt
);

  localparam logic [3:0] BUSY_INIT = 4'(MUL_LAT - 1);

  // Shadow of the instructions now in EX and MEM. The WB stage and the
  // load/mul flags of MEM never influence a decision, so they are not kept:
  // the multi-cycle counter is armed when the op enters EX, and only the
  // load currently in EX can cause a load-use stall.
  logic             ex_valid;
  logic [REG_W-1:0] ex_rw;
  logic             ex_regwr;
  logic             ex_memrd;
  logic             mem_valid;
  logic [REG_W-1:0] mem_rw;
  logic             mem_regwr;

  logic             freeze;
  logic             load_use;
  logic             enter;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;

  // A stage produces register r; register 0 is hardwired and never matches.
  function automatic logic writes(input logic v, input logic wr,
                                  input logic [REG_W-1:0] rw,
                                  input logic [REG_W-1:0] r);
    return v && wr && (rw == r) && (r != '0);
  endfunction

  // Nearest producer wins: EX (moving to EX/MEM) before MEM (moving to MEM/WB).
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] r,
                                         input logic ev, input logic ew,
                                         input logic [REG_W-1:0] erw,
                                         input logic mv, input logic mw,
                                         input logic [REG_W-1:0] mrw);
    if (writes(ev, ew, erw, r))
      return 2'b01;
    else if (writes(mv, mw, mrw, r))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign freeze   = (busy_cnt != 4'd0);
  assign load_use = id_valid && ex_memrd &&
                    (writes(ex_valid, ex_regwr, ex_rw, id_rs) ||
                     (id_rt_used && writes(ex_valid, ex_regwr, ex_rw, id_rt)));
  assign enter    = id_valid && !idex_bubble;
  assign sel_a    = fwd_sel(id_rs, ex_valid, ex_regwr, ex_rw, mem_valid, mem_regwr, mem_rw);
  assign sel_b    = id_rt_used ?
                    fwd_sel(id_rt, ex_valid, ex_regwr, ex_rw, mem_valid, mem_regwr, mem_rw) :
                    2'b00;

  // Pipeline control by priority: freeze, then taken branch, then load-use stall.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    if (!reset) begin
      if (freeze) begin
        ex_hold = 1'b1;
        pc_en   = 1'b0;
        ifid_en = 1'b0;
      end else if (ex_br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // Shadow pipeline advance, forwarding-select registration and freeze countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_rw     <= '0;
      ex_regwr  <= 1'b0;
      ex_memrd  <= 1'b0;
      mem_valid <= 1'b0;
      mem_rw    <= '0;
      mem_regwr <= 1'b0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
      busy_cnt  <= 4'd0;
    end else if (freeze) begin
      busy_cnt <= busy_cnt - 4'd1;
    end else begin
      mem_valid <= ex_valid;
      mem_rw    <= ex_rw;
      mem_regwr <= ex_regwr;
      ex_valid  <= enter;
      ex_rw     <= enter ? id_rw : '0;
      ex_regwr  <= enter && id_regwr;
      ex_memrd  <= enter && id_memrd;
      fwd_a_sel <= enter ? sel_a : 2'b00;
      fwd_b_sel <= enter ? sel_b : 2'b00;
      busy_cnt  <= (enter && id_mul) ? BUSY_INIT : 4'd0;
    end
  end

endmodule
